// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB-lite arbiter in front of the AHB2APB bridge slave port.
// Ports: Hclk/Hresetn, m_* master side, H* bridge side (see port list).
module ahb_bridge_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BEATS   = 8
) (
  input  logic                              Hclk,
  input  logic                              Hresetn,
  input  logic [NUM_MASTERS-1:0]            m_hbusreq,
  output logic [NUM_MASTERS-1:0]            m_hgrant,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr,
  input  logic [NUM_MASTERS*2-1:0]          m_htrans,
  input  logic [NUM_MASTERS-1:0]            m_hwrite,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata,
  output logic                              m_hready,
  output logic [DATA_WIDTH-1:0]             m_hrdata,
  output logic [1:0]                        m_hresp,
  output logic [ADDR_WIDTH-1:0]             Haddr,
  output logic [1:0]                        Htrans,
  output logic                              Hwrite,
  output logic [DATA_WIDTH-1:0]             Hwdata,
  output logic                              Hreadyin,
  input  logic                              Hreadyout,
  input  logic [DATA_WIDTH-1:0]             Hrdata,
  input  logic [1:0]                        Hresp
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OWNED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] dpo_q, dpo_d;
  logic          dpv_q, dpv_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    cnt_inc;
  logic [IW:0]   sel_idle, sel_next;
  logic          rearb;

  // {found, index}: first requester scanning from start+off, circular.
  function automatic logic [IW:0] pick(
    input logic [NUM_MASTERS-1:0] req,
    input logic [IW-1:0]          start,
    input int                     off
  );
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = (int'(start) + off + k) % NUM_MASTERS;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  assign m_hready = Hreadyout;
  assign Hreadyin = Hreadyout;
  assign m_hrdata = Hrdata;
  assign m_hresp  = Hresp;

  always_comb begin
    m_hgrant = '0;
    Haddr    = '0;
    Htrans   = 2'b00;
    Hwrite   = 1'b0;
    if (state_q == S_OWNED) begin
      m_hgrant[own_q] = 1'b1;
      Haddr  = m_haddr[own_q*ADDR_WIDTH +: ADDR_WIDTH];
      Htrans = m_htrans[own_q*2 +: 2];
      Hwrite = m_hwrite[own_q];
    end
  end

  assign Hwdata = dpv_q ? m_hwdata[dpo_q*DATA_WIDTH +: DATA_WIDTH]
                        : '0;

  // Beat count includes the beat accepted on this edge.
  assign cnt_inc  = (Htrans[1] && cnt_q != 8'hFF) ? cnt_q + 8'd1
                                                  : cnt_q;
  assign sel_idle = pick(m_hbusreq, rr_q, 0);
  // Offset 1 makes the current owner the lowest priority.
  assign sel_next = pick(m_hbusreq, own_q, 1);
  assign rearb    = !m_hbusreq[own_q] ||
                    (cnt_inc >= 8'(MAX_BEATS));

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    dpo_d   = dpo_q;
    dpv_d   = dpv_q;
    if (Hreadyout) begin
      dpo_d = own_q;
      dpv_d = (state_q == S_OWNED) && Htrans[1];
      case (state_q)
        S_IDLE: begin
          if (|m_hbusreq) begin
            state_d = S_OWNED;
            own_d   = sel_idle[IW-1:0];
            cnt_d   = '0;
          end
        end
        default: begin
          if (rearb) begin
            rr_d  = (own_q == IW'(NUM_MASTERS-1)) ? '0
                                                  : own_q + 1'b1;
            cnt_d = '0;
            if (sel_next[IW]) own_d = sel_next[IW-1:0];
            else              state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= S_IDLE;
      own_q   <= '0;
      rr_q    <= '0;
      dpo_q   <= '0;
      dpv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      dpo_q   <= dpo_d;
      dpv_q   <= dpv_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench for ahb_bridge_arbiter.
// Directed scenarios with literal checks, then random traffic vs a model.
module tb_ahb_bridge_arbiter;
  localparam int N    = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 8;

  logic            Hclk = 1'b0;
  logic            Hresetn;
  logic [N-1:0]    m_hbusreq, m_hgrant, m_hwrite;
  logic [N*AW-1:0] m_haddr;
  logic [N*2-1:0]  m_htrans;
  logic [N*DW-1:0] m_hwdata;
  logic            m_hready;
  logic [DW-1:0]   m_hrdata;
  logic [1:0]      m_hresp;
  logic [AW-1:0]   Haddr;
  logic [1:0]      Htrans;
  logic            Hwrite;
  logic [DW-1:0]   Hwdata;
  logic            Hreadyin, Hreadyout;
  logic [DW-1:0]   Hrdata;
  logic [1:0]      Hresp;

  logic [AW-1:0] a[N];
  logic [1:0]    t[N];
  logic [DW-1:0] d[N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_haddr[i*AW +: AW] = a[i];
      m_htrans[i*2 +: 2]  = t[i];
      m_hwdata[i*DW +: DW] = d[i];
    end
  end

  always #5 Hclk = ~Hclk;

  ahb_bridge_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .MAX_BEATS(MAXB)
  ) dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .m_hbusreq(m_hbusreq), .m_hgrant(m_hgrant),
    .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
    .m_hready(m_hready), .m_hrdata(m_hrdata),
    .m_hresp(m_hresp), .Haddr(Haddr), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hwdata(Hwdata), .Hreadyin(Hreadyin),
    .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hresp(Hresp)
  );

  int checks = 0;
  int failures = 0;

  // Model: owner index or -1 when nobody holds the bus.
  int own, rr, cnt, dpo;
  bit dpv;

  task automatic chk_eq(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; rr = 0; cnt = 0; dpo = 0; dpv = 0;
  endtask

  function automatic int scan(input int start, input int off);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + off + k) % N;
      if (m_hbusreq[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (!Hresetn) begin
      model_reset();
      return;
    end
    if (!Hreadyout) return;
    if (own < 0) begin
      dpv = 0;
      if (m_hbusreq != '0) begin
        own = scan(rr, 0);
        cnt = 0;
      end
    end else begin
      int beat;
      beat = int'(t[own][1]);
      dpo = own;
      dpv = bit'(beat);
      cnt = (cnt + beat > 255) ? 255 : cnt + beat;
      if (!m_hbusreq[own] || cnt >= MAXB) begin
        rr  = (own + 1) % N;
        own = scan(own, 1);
        cnt = 0;
      end
    end
  endtask

  task automatic chk_model();
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    logic [1:0]    et;
    logic          ew;
    logic [DW-1:0] ed;
    #1;
    eg = '0; ea = '0; et = 2'b00; ew = 1'b0;
    if (own >= 0) begin
      eg[own] = 1'b1;
      ea = a[own];
      et = t[own];
      ew = m_hwrite[own];
    end
    ed = dpv ? d[dpo] : '0;
    chk_eq("grant", 64'(m_hgrant), 64'(eg));
    chk_eq("haddr", 64'(Haddr), 64'(ea));
    chk_eq("htrans", 64'(Htrans), 64'(et));
    chk_eq("hwrite", 64'(Hwrite), 64'(ew));
    chk_eq("hwdata", 64'(Hwdata), 64'(ed));
    chk_eq("ready", 64'({m_hready, Hreadyin}),
           64'({Hreadyout, Hreadyout}));
    chk_eq("rdata_resp", 64'({m_hresp, m_hrdata}),
           64'({Hresp, Hrdata}));
  endtask

  task automatic cyc();
    chk_model();
    @(posedge Hclk);
    model_step();
    @(negedge Hclk);
  endtask

  task automatic clear_inputs();
    m_hbusreq = '0;
    m_hwrite  = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0; t[i] = 2'b00; d[i] = '0;
    end
    Hreadyout = 1'b1;
    Hrdata    = '0;
    Hresp     = 2'b00;
  endtask

  task automatic do_reset();
    clear_inputs();
    Hresetn = 1'b0;
    model_reset();
    cyc();
    cyc();
    Hresetn = 1'b1;
  endtask

  initial begin
    Hresetn = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge Hclk);

    // Reset values and idle bus
    do_reset();
    #1;
    chk_eq("rst_grant", 64'(m_hgrant), 64'h0);
    chk_eq("rst_htrans", 64'(Htrans), 64'h0);
    chk_eq("rst_haddr", 64'(Haddr), 64'h0);
    a[0] = 32'h1234_5678;
    t[0] = 2'b10;
    repeat (3) cyc();
    #1;
    chk_eq("idle_grant", 64'(m_hgrant), 64'h0);
    chk_eq("idle_htrans", 64'(Htrans), 64'h0);
    chk_eq("idle_haddr", 64'(Haddr), 64'h0);

    // Single write from master 0
    do_reset();
    m_hbusreq = 2'b01;
    cyc();
    a[0] = 32'h8000_0004;
    t[0] = 2'b10;
    m_hwrite[0] = 1'b1;
    #1;
    chk_eq("w_grant", 64'(m_hgrant), 64'h1);
    chk_eq("w_haddr", 64'(Haddr), 64'h8000_0004);
    chk_eq("w_htrans", 64'(Htrans), 64'h2);
    cyc();
    t[0] = 2'b00;
    d[0] = 32'hA5A5_5A5A;
    #1;
    chk_eq("w_hwdata", 64'(Hwdata), 64'hA5A5_5A5A);
    cyc();

    // Round-robin contention
    do_reset();
    m_hbusreq = 2'b11;
    cyc();
    #1;
    chk_eq("rr_first", 64'(m_hgrant), 64'h1);
    m_hbusreq = 2'b10;
    cyc();
    #1;
    chk_eq("rr_second", 64'(m_hgrant), 64'h2);
    m_hbusreq = 2'b00;
    cyc();
    m_hbusreq = 2'b11;
    cyc();
    #1;
    chk_eq("rr_third", 64'(m_hgrant), 64'h1);

    // Beat cap forces handover
    do_reset();
    m_hbusreq = 2'b01;
    cyc();
    m_hbusreq = 2'b11;
    for (int k = 1; k <= MAXB; k++) begin
      t[0] = (k == 1) ? 2'b10 : 2'b11;
      a[0] = 32'h8000_0000 + 32'(4 * k);
      d[0] = 32'hD0D0_0000 + 32'(k - 1);
      #1;
      chk_eq("cap_hold", 64'(m_hgrant), 64'h1);
      cyc();
    end
    d[0] = 32'hD0D0_0008;
    #1;
    chk_eq("cap_switch", 64'(m_hgrant), 64'h2);
    chk_eq("cap_hwdata", 64'(Hwdata), 64'hD0D0_0008);
    cyc();

    // Wait states freeze the arbiter
    do_reset();
    m_hbusreq = 2'b10;
    cyc();
    t[1] = 2'b10;
    a[1] = 32'h8000_00FF;
    d[1] = 32'h0BAD_F00D;
    m_hwrite[1] = 1'b1;
    m_hbusreq = 2'b11;
    #1;
    chk_eq("ws_grant0", 64'(m_hgrant), 64'h2);
    cyc();
    t[1] = 2'b00;
    Hreadyout = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_eq("ws_grant", 64'(m_hgrant), 64'h2);
      chk_eq("ws_haddr", 64'(Haddr), 64'h8000_00FF);
      chk_eq("ws_hwdata", 64'(Hwdata), 64'h0BAD_F00D);
      if (k == 2) m_hbusreq = 2'b01;
      cyc();
    end
    #1;
    chk_eq("ws_still", 64'(m_hgrant), 64'h2);
    Hreadyout = 1'b1;
    cyc();
    #1;
    chk_eq("ws_after", 64'(m_hgrant), 64'h1);

    // Asynchronous reset mid-transfer
    do_reset();
    m_hbusreq = 2'b10;
    cyc();
    t[1] = 2'b10;
    m_hwrite[1] = 1'b1;
    d[1] = 32'h1234_5678;
    cyc();
    #1;
    chk_eq("ar_pre", 64'(Hwdata), 64'h1234_5678);
    #1;
    Hresetn = 1'b0;
    #1;
    chk_eq("ar_grant", 64'(m_hgrant), 64'h0);
    chk_eq("ar_htrans", 64'(Htrans), 64'h0);
    chk_eq("ar_hwdata", 64'(Hwdata), 64'h0);
    model_reset();
    @(negedge Hclk);
    clear_inputs();
    Hresetn = 1'b1;
    m_hbusreq = 2'b11;
    cyc();
    #1;
    chk_eq("ar_after", 64'(m_hgrant), 64'h1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) m_hbusreq[i] = ~m_hbusreq[i];
        case ($urandom_range(0, 3))
          0:       t[i] = 2'b00;
          1:       t[i] = 2'b10;
          default: t[i] = 2'b11;
        endcase
        a[i] = $urandom;
        d[i] = $urandom;
        m_hwrite[i] = 1'($urandom_range(0, 1));
      end
      Hreadyout = ($urandom_range(0, 3) != 0);
      Hrdata = $urandom;
      Hresp = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
